// File: rtl/arbitro_botoes_pkg.sv
// ---------------------------------------------------------------------------
// arbitro_botoes_pkg
// Shared definitions for the button arbiter: button indices, menu FSM state
// encoding and the fixed-priority winner helper.
// ---------------------------------------------------------------------------
package arbitro_botoes_pkg;

    localparam int unsigned N_BOTOES = 3;
    localparam int unsigned BOT_A    = 0;   // next
    localparam int unsigned BOT_B    = 1;   // confirm
    localparam int unsigned BOT_C    = 2;   // cancel

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        MENU   = 2'd1,
        EMITE  = 2'd2
    } estado_t;

    // One-hot highest-priority pending bit (C > B > A); zero if none pending.
    function automatic logic [N_BOTOES-1:0] vencedor(input logic [N_BOTOES-1:0] pend);
        logic [N_BOTOES-1:0] v;
        v = '0;
        if (pend[BOT_C])      v[BOT_C] = 1'b1;
        else if (pend[BOT_B]) v[BOT_B] = 1'b1;
        else if (pend[BOT_A]) v[BOT_A] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arbitro_botoes_if.sv
// ---------------------------------------------------------------------------
// arbitro_botoes_if
// Valid/ready action channel from the arbiter to the game logic.
//   acao_valid  : action code is valid (master -> slave)
//   acao_codigo : selected menu item   (master -> slave)
//   acao_ready  : game logic accepts   (slave -> master)
// ---------------------------------------------------------------------------
interface arbitro_botoes_if #(
    parameter int unsigned LARG_COD = 2
) ();
    logic                acao_valid;
    logic                acao_ready;
    logic [LARG_COD-1:0] acao_codigo;

    modport master (output acao_valid, output acao_codigo, input acao_ready);
    modport slave  (input acao_valid, input acao_codigo, output acao_ready);
endinterface

// File: rtl/arbitro_botoes_temporizador_descendente.sv
// ---------------------------------------------------------------------------
// temporizador_descendente
// Loadable down-counter that stops at zero, with a zero flag.
//   clk, rst   : clock, synchronous active-high reset (count -> 0)
//   i_carga    : load i_valor this edge (overrides decrement)
//   i_valor    : load value
//   o_zero_c   : count is zero (combinational decode of the count register)
// ---------------------------------------------------------------------------
module temporizador_descendente #(
    parameter int unsigned LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_carga,
    input  logic [LARGURA-1:0] i_valor,
    output logic               o_zero_c
);

    logic [LARGURA-1:0] r_contagem;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_contagem <= '0;
        end else if (i_carga) begin
            r_contagem <= i_valor;
        end else if (r_contagem != '0) begin
            r_contagem <= r_contagem - LARGURA'(1);
        end
    end

    assign o_zero_c = (r_contagem == '0);

endmodule

// File: rtl/arbitro_botoes.sv
// ---------------------------------------------------------------------------
// arbitro_botoes
// Latches debounced button pulses, arbitrates them with fixed priority
// (C > B > A), enforces a lockout between consumed events and runs the menu
// FSM (navigate / confirm / cancel / inactivity timeout). The confirmed item
// is handed to the game logic on a valid/ready channel.
//   clk, rst    : clock, synchronous active-high reset
//   b_pulsos    : one-cycle pulses, bit0=A next, bit1=B confirm, bit2=C cancel
//   acao        : action channel (master side): valid, codigo, ready
//   cursor      : current menu highlight
//   menu_ativo  : high while the FSM is in MENU
// ---------------------------------------------------------------------------
module arbitro_botoes
    import arbitro_botoes_pkg::*;
#(
    parameter  int unsigned N_ITENS  = 4,
    parameter  int unsigned LOCKOUT  = 1000,
    parameter  int unsigned TIMEOUT  = 50_000_000,
    localparam int unsigned LARG_COD = $clog2(N_ITENS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_BOTOES-1:0]   b_pulsos,
    arbitro_botoes_if.master      acao,
    output logic [LARG_COD-1:0]   cursor,
    output logic                  menu_ativo
);

    localparam int unsigned LARG_LOCK = (LOCKOUT < 1) ? 1 : $clog2(LOCKOUT + 1);
    localparam int unsigned LARG_TMO  = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT);

    estado_t               r_estado;
    logic [N_BOTOES-1:0]   r_pendente;
    logic [LARG_TMO-1:0]   r_tmo;
    logic [LARG_COD-1:0]   r_cursor;
    logic [LARG_COD-1:0]   r_codigo;
    logic                  r_valid;
    logic                  r_menu;

    logic                  w_lock_zero;
    logic                  w_consome;
    logic [N_BOTOES-1:0]   w_venc;
    logic [N_BOTOES-1:0]   w_limpa;
    logic [LARG_COD-1:0]   w_cursor_prox;

    // Arbitration: an event is taken only outside EMITE and after lockout.
    assign w_venc        = vencedor(r_pendente);
    assign w_consome     = (r_pendente != '0) && w_lock_zero && (r_estado != EMITE);
    assign w_limpa       = w_consome ? w_venc : '0;
    assign w_cursor_prox = (r_cursor == LARG_COD'(N_ITENS - 1)) ? '0
                                                                : r_cursor + LARG_COD'(1);

    // Pending latch: new pulses OR in after the winner clears, so set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pendente <= '0;
        end else begin
            r_pendente <= (r_pendente & ~w_limpa) | b_pulsos;
        end
    end

    // Lockout window reloaded on every consumed event.
    temporizador_descendente #(
        .LARGURA (LARG_LOCK)
    ) u_lockout (
        .clk      (clk),
        .rst      (rst),
        .i_carga  (w_consome),
        .i_valor  (LARG_LOCK'(LOCKOUT)),
        .o_zero_c (w_lock_zero)
    );

    // Menu FSM with registered outputs and inline inactivity counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= OCIOSO;
            r_tmo    <= '0;
            r_cursor <= '0;
            r_codigo <= '0;
            r_valid  <= 1'b0;
            r_menu   <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    // Cancel while idle is consumed and discarded.
                    if (w_consome && (w_venc[BOT_A] || w_venc[BOT_B])) begin
                        r_estado <= MENU;
                        r_cursor <= '0;
                        r_tmo    <= '0;
                        r_menu   <= 1'b1;
                    end
                end
                MENU: begin
                    if (w_consome) begin
                        // A consumed event always beats a coinciding timeout.
                        r_tmo <= '0;
                        if (w_venc[BOT_C]) begin
                            r_estado <= OCIOSO;
                            r_cursor <= '0;
                            r_menu   <= 1'b0;
                        end else if (w_venc[BOT_B]) begin
                            r_estado <= EMITE;
                            r_codigo <= r_cursor;
                            r_valid  <= 1'b1;
                            r_menu   <= 1'b0;
                        end else begin
                            r_cursor <= w_cursor_prox;
                        end
                    end else if (r_tmo == LARG_TMO'(TIMEOUT - 1)) begin
                        r_estado <= OCIOSO;
                        r_cursor <= '0;
                        r_tmo    <= '0;
                        r_menu   <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + LARG_TMO'(1);
                    end
                end
                EMITE: begin
                    if (r_valid && acao.acao_ready) begin
                        r_estado <= OCIOSO;
                        r_valid  <= 1'b0;
                        r_cursor <= '0;
                    end
                end
                default: begin
                    r_estado <= OCIOSO;
                    r_cursor <= '0;
                    r_valid  <= 1'b0;
                    r_menu   <= 1'b0;
                end
            endcase
        end
    end

    assign acao.acao_valid  = r_valid;
    assign acao.acao_codigo = r_codigo;
    assign cursor           = r_cursor;
    assign menu_ativo       = r_menu;

endmodule

// File: tb/tb_arbitro_botoes.sv
// ---------------------------------------------------------------------------
// tb_arbitro_botoes
// Self-checking bench for arbitro_botoes (N_ITENS=4, LOCKOUT=4, TIMEOUT=20).
// A vector table, hand-written corner sequences and a random phase; every
// edge is also checked against a timestamp-based reference model.
// ---------------------------------------------------------------------------
module tb_arbitro_botoes;

    localparam int unsigned N_ITENS = 4;
    localparam int unsigned LOCKOUT = 4;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned LCOD    = 2;

    localparam logic [2:0] PA = 3'b001;
    localparam logic [2:0] PB = 3'b010;
    localparam logic [2:0] PC = 3'b100;

    // Reference-model modes (independent of the RTL encoding)
    localparam int M_IDLE = 0;
    localparam int M_MENU = 1;
    localparam int M_EMIT = 2;

    logic            clk;
    logic            rst;
    logic [2:0]      b_pulsos;
    logic [LCOD-1:0] cursor;
    logic            menu_ativo;

    arbitro_botoes_if #(.LARG_COD(LCOD)) u_if ();

    arbitro_botoes #(
        .N_ITENS (N_ITENS),
        .LOCKOUT (LOCKOUT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .b_pulsos   (b_pulsos),
        .acao       (u_if),
        .cursor     (cursor),
        .menu_ativo (menu_ativo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---- reference model: pending set, timestamps, mode ----
    bit m_pend [3];
    int m_edge    = 0;
    int m_ok_at   = 0;   // earliest edge index a consumption may happen
    int m_since   = 0;   // edge of menu entry / last consumption in menu
    int m_mode    = M_IDLE;
    int m_cur     = 0;
    int m_cod     = 0;
    bit m_valid   = 1'b0;

    task automatic model_edge();
        int win;
        m_edge++;
        if (rst) begin
            for (int b = 0; b < 3; b++) m_pend[b] = 1'b0;
            m_ok_at = 0; m_mode = M_IDLE; m_cur = 0; m_cod = 0; m_valid = 1'b0;
            return;
        end
        win = -1;
        if (m_mode != M_EMIT && m_edge >= m_ok_at) begin
            for (int b = 2; b >= 0; b--) begin
                if (m_pend[b] && win < 0) win = b;
            end
        end
        if (win >= 0) begin
            m_pend[win] = 1'b0;
            m_ok_at = m_edge + LOCKOUT + 1;
        end
        case (m_mode)
            M_IDLE: if (win == 0 || win == 1) begin
                m_mode = M_MENU; m_cur = 0; m_since = m_edge;
            end
            M_MENU: begin
                if (win >= 0) begin
                    m_since = m_edge;
                    if (win == 2) begin m_mode = M_IDLE; m_cur = 0; end
                    else if (win == 1) begin m_mode = M_EMIT; m_cod = m_cur; m_valid = 1'b1; end
                    else m_cur = (m_cur + 1) % N_ITENS;
                end else if (m_edge - m_since == TIMEOUT) begin
                    m_mode = M_IDLE; m_cur = 0;
                end
            end
            default: if (u_if.acao_ready) begin
                m_mode = M_IDLE; m_valid = 1'b0; m_cur = 0;
            end
        endcase
        for (int b = 0; b < 3; b++) if (b_pulsos[b]) m_pend[b] = 1'b1;
    endtask

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nome, $time, got, exp);
        end
    endtask

    // One clock edge: advance model, then compare DUT against it after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("mdl_menu",   32'(menu_ativo),       32'(m_mode == M_MENU));
        chk("mdl_cursor", 32'(cursor),           32'(m_cur));
        chk("mdl_valid",  32'(u_if.acao_valid),  32'(m_valid));
        if (m_valid) chk("mdl_codigo", 32'(u_if.acao_codigo), 32'(m_cod));
    endtask

    task automatic pulse_step(input logic [2:0] p);
        b_pulsos = p;
        step();
        b_pulsos = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1; b_pulsos = 3'b000; u_if.acao_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Wait out lockout, pulse, then let the event be consumed.
    task automatic bump(input logic [2:0] p);
        repeat (4) step();
        pulse_step(p);
        step();
    endtask

    task automatic enter_menu();
        pulse_step(PA);
        step();
        chk("entra_menu", 32'(menu_ativo), 32'd1);
    endtask

    typedef struct {
        logic            rst;
        logic [2:0]      pul;
        logic            rdy;
        logic            e_menu;
        logic [LCOD-1:0] e_cur;
        logic            e_valid;
        logic [LCOD-1:0] e_cod;
    } vec_t;

    vec_t tab [24];

    initial begin
        int dens;
        int exp_cur [5];
        rst = 1'b1; b_pulsos = 3'b000; u_if.acao_ready = 1'b0;

        // ---- table: rst, pulses, ready | menu, cursor, valid, codigo ----
        for (int i = 0; i < 24; i++) tab[i] = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
        tab[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
        tab[2]  = '{1'b0, PA,     1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
        tab[3]  = '{1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0};
        tab[4]  = '{1'b0, PA,     1'b0, 1'b1, 2'd0, 1'b0, 2'd0};
        for (int i = 5; i <= 7; i++) tab[i] = '{1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0};
        tab[8]  = '{1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0};
        tab[9]  = '{1'b0, PB,     1'b0, 1'b1, 2'd1, 1'b0, 2'd0};
        for (int i = 10; i <= 12; i++) tab[i] = '{1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0};
        tab[13] = '{1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 1'b1, 2'd1};
        tab[14] = '{1'b0, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0};
        tab[15] = '{1'b0, PC,     1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
        tab[17] = '{1'b0, PA,     1'b0, 1'b0, 2'd0, 1'b0, 2'd0};
        tab[23] = '{1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0};

        for (int i = 0; i < 24; i++) begin
            rst = tab[i].rst; b_pulsos = tab[i].pul; u_if.acao_ready = tab[i].rdy;
            step();
            chk($sformatf("tab%0d_menu", i),   32'(menu_ativo),      32'(tab[i].e_menu));
            chk($sformatf("tab%0d_cursor", i), 32'(cursor),          32'(tab[i].e_cur));
            chk($sformatf("tab%0d_valid", i),  32'(u_if.acao_valid), 32'(tab[i].e_valid));
            if (tab[i].e_valid) chk($sformatf("tab%0d_codigo", i), 32'(u_if.acao_codigo), 32'(tab[i].e_cod));
        end
        rst = 1'b0; b_pulsos = 3'b000; u_if.acao_ready = 1'b0;

        // ---- cursor wraps: 1,2,3,0,1 ----
        do_reset();
        enter_menu();
        chk("wrap_start", 32'(cursor), 32'd0);
        exp_cur = '{1, 2, 3, 0, 1};
        for (int i = 0; i < 5; i++) begin
            bump(PA);
            chk($sformatf("wrap_cursor%0d", i), 32'(cursor), 32'(exp_cur[i]));
        end

        // ---- A and C together: C first, A five edges later ----
        do_reset();
        enter_menu();
        repeat (4) step();
        pulse_step(PA | PC);
        step();
        chk("ac_c_first_menu", 32'(menu_ativo), 32'd0);
        chk("ac_c_first_cur",  32'(cursor),     32'd0);
        repeat (4) step();
        chk("ac_a_waiting", 32'(menu_ativo), 32'd0);
        step();
        chk("ac_a_menu", 32'(menu_ativo), 32'd1);
        chk("ac_a_cur",  32'(cursor),     32'd0);

        // ---- held action with ready low, pending A afterwards ----
        do_reset();
        enter_menu();
        bump(PA);
        bump(PA);
        chk("emit_cur2", 32'(cursor), 32'd2);
        bump(PB);
        for (int i = 0; i < 7; i++) begin
            if (i == 0) pulse_step(PA); else step();
            chk("emit_hold_valid", 32'(u_if.acao_valid),  32'd1);
            chk("emit_hold_cod",   32'(u_if.acao_codigo), 32'd2);
            chk("emit_hold_menu",  32'(menu_ativo),       32'd0);
        end
        u_if.acao_ready = 1'b1;
        step();
        u_if.acao_ready = 1'b0;
        chk("emit_drop_valid", 32'(u_if.acao_valid), 32'd0);
        chk("emit_drop_cur",   32'(cursor),          32'd0);
        chk("emit_drop_menu",  32'(menu_ativo),      32'd0);
        step();
        chk("emit_pend_a_menu", 32'(menu_ativo), 32'd1);

        // ---- inactivity timeout, then event on the timeout edge ----
        do_reset();
        enter_menu();
        for (int i = 1; i < 20; i++) step();
        chk("tmo_before", 32'(menu_ativo), 32'd1);
        step();
        chk("tmo_fall", 32'(menu_ativo), 32'd0);
        enter_menu();
        repeat (18) step();
        pulse_step(PA);
        step();
        chk("tmo_evt_menu", 32'(menu_ativo), 32'd1);
        chk("tmo_evt_cur",  32'(cursor),     32'd1);
        for (int i = 1; i < 20; i++) step();
        chk("tmo2_before", 32'(menu_ativo), 32'd1);
        step();
        chk("tmo2_fall", 32'(menu_ativo), 32'd0);

        // ---- reset while an action is held; pulse on reset edge dropped ----
        do_reset();
        enter_menu();
        bump(PB);
        chk("rst_pre_valid", 32'(u_if.acao_valid), 32'd1);
        rst = 1'b1; b_pulsos = PA;
        step();
        rst = 1'b0; b_pulsos = 3'b000;
        chk("rst_valid",  32'(u_if.acao_valid),  32'd0);
        chk("rst_codigo", 32'(u_if.acao_codigo), 32'd0);
        chk("rst_cursor", 32'(cursor),           32'd0);
        chk("rst_menu",   32'(menu_ativo),       32'd0);
        repeat (2) step();
        chk("rst_pulse_ignored", 32'(menu_ativo), 32'd0);

        // ---- random phase against the model ----
        do_reset();
        for (int blk = 0; blk < 30; blk++) begin
            dens = (blk % 3 == 0) ? 60 : 6;
            for (int c = 0; c < 100; c++) begin
                rst = ($urandom_range(0, 299) == 0);
                for (int b = 0; b < 3; b++) b_pulsos[b] = ($urandom_range(0, dens - 1) == 0);
                u_if.acao_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arbitro_botoes.md
Name: arbitro_botoes

Overview:
- Sits between the three per-button debouncer/one-shot instances and the game logic.
- Latches each one-shot pulse, then arbitrates simultaneous presses with fixed priority.
- Enforces an inter-event lockout window and drives a small menu FSM: cursor navigation, confirm, cancel and inactivity timeout.
- Hands the confirmed menu action to game logic over a valid/ready handshake.

Parameters:
- N_ITENS, 4: number of menu items; cursor range 0..N_ITENS-1; must be >= 2.
- LOCKOUT, 1000: idle cycles enforced after every consumed event.
- TIMEOUT, 50_000_000: cycles without a consumed event in MENU before the block returns to OCIOSO.
- LARG_COD, $clog2(N_ITENS): derived localparam; width of cursor and action code.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- b_pulsos  in  3  one-cycle pulses from the debouncers; bit0=A (next), bit1=B (confirm), bit2=C (cancel).
- acao_ready  in  1  game logic accepts the action.
- acao_valid  out  1  action code is valid.
- acao_codigo  out  LARG_COD  selected menu item.
- cursor  out  LARG_COD  current menu highlight.
- menu_ativo  out  1  high while FSM is in MENU.

Behaviour:
- Reset values: all outputs 0, pendente=000, lockout counter 0, timeout counter 0, FSM in OCIOSO.
- Pending latch: pendente[i] is set at the edge where b_pulsos[i] is sampled high, and cleared when consumed.
  - Set and clear on the same bit in the same edge: set wins.
  - Repeated pulses on a bit that is already pending merge into one event.
- Consumption is allowed when all of these hold: pendente != 0, lockout counter == 0, FSM != EMITE.
  - Winner is the highest priority pending bit: C > B > A.
  - Only the winner bit clears; losers stay pending.
  - Pulses arriving during EMITE or during lockout stay latched.
- Lockout counter:
  - Loaded with LOCKOUT at the consumption edge k.
  - Decrements at edges k+1..k+LOCKOUT.
  - Next consumption is possible at edge k+LOCKOUT+1 at the earliest.
  - LOCKOUT=0 allows consumption on consecutive edges.
- Latency: a pulse sampled at edge k can be consumed at edge k+1 at the earliest; FSM outputs change at that edge.
- FSM OCIOSO:
  - A or B consumed -> MENU, cursor=0, timeout counter cleared.
  - C consumed -> discarded (lockout still loads), stays in OCIOSO.
- FSM MENU (menu_ativo=1):
  - A -> cursor+1; wraps N_ITENS-1 -> 0.
  - B -> EMITE; acao_codigo=cursor, acao_valid=1.
  - C -> OCIOSO; cursor=0.
  - Timeout counter clears on every consumption and otherwise increments each cycle.
  - At the edge where timeout counter == TIMEOUT-1 and nothing is consumed -> OCIOSO, cursor=0.
  - If a consumption coincides with timeout, the event wins.
- FSM EMITE:
  - acao_valid and acao_codigo are held stable until acao_valid && acao_ready is sampled.
  - On that edge: acao_valid=0, FSM -> OCIOSO, cursor=0.
  - No timeout applies in EMITE.
- Reset asserted in any state returns everything to reset values at that edge.
  - A held action is dropped, and acao_valid is low from the next cycle.
  - Pulses sampled on a reset edge are discarded.

Decomposition:
- Shared package holds:
  - button index constants BOT_A=0, BOT_B=1, BOT_C=2;
  - FSM state encoding OCIOSO/MENU/EMITE (2 bits).
- One natural sub-module, temporizador_descendente (parameterised width), loadable down-counter with a zero flag; instantiated for the lockout.
- The timeout counter stays inline.

Test Plan:
- All tests use N_ITENS=4, LOCKOUT=4, TIMEOUT=20.
- Reset, then single A pulse at edge 10 -> menu_ativo=1 and cursor=0 after edge 11; pendente=000.
- In MENU, 5 A pulses spaced 6 cycles apart -> cursor sequence 1,2,3,0,1 (wrap).
- In MENU, pulses A and C in the same cycle -> C consumed first (OCIOSO, cursor=0).
  - A stays pending and is consumed 5 edges later -> MENU, cursor=0.
- MENU with cursor=2, then B pulse with acao_ready held 0 for 7 cycles -> acao_valid=1 and acao_codigo=2 stay stable.
  - An A pulse during this window is still pending afterwards.
  - Raise acao_ready -> valid drops next edge; FSM returns to OCIOSO, then the pending A re-enters MENU after the lockout.
- Enter MENU, apply no pulses -> menu_ativo falls exactly 20 cycles after the entry edge.
  - Repeat with an A pulse consumed on the timeout edge -> stays in MENU and the counter restarts.
- Assert rst for 1 cycle while in EMITE with acao_valid=1 -> all outputs 0 next cycle; a pulse on the reset edge is ignored.
